// File: rtl/seg_display_arbiter_if.sv
// Requester-side bus of the display arbiter: request levels and words in,
// current owner, forwarded display word and scan tick out.
interface seg_display_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int OW = $clog2(N_REQ);

   logic [N_REQ-1:0]    req;
   logic [20*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]    grant;
   logic [OW-1:0]       owner;
   logic [19:0]         disp_data;
   logic                disp_oe;
   logic                scan_tick;

   modport master (
      output req, req_data,
      input  grant, owner, disp_data, disp_oe, scan_tick
   );

   modport slave (
      input  req, req_data,
      output grant, owner, disp_data, disp_oe, scan_tick
   );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit display with a minimum dwell time,
// a one-cycle blank between owners, and the driver's scan tick prescaler.
module seg_display_arbiter #(
   parameter int N_REQ       = 4,
   parameter int TICK_DIV    = 65536,
   parameter int DWELL_TICKS = 256
) (
   input logic               clk,
   input logic               rst,
   seg_display_arbiter_if.slave bus
);
   localparam int OW = $clog2(N_REQ);
   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DWELL_TICKS + 1);

   typedef enum logic [1:0] {IDLE, GRANT, BLANK} state_t;

   state_t           state;
   logic [PW-1:0]    prescaler;
   logic             scan_tick;
   logic [DW-1:0]    dwell;
   logic [OW-1:0]    owner;
   logic [N_REQ-1:0] grant;
   logic [19:0]      disp_data;
   logic             disp_oe;

   logic [OW-1:0]    winner;
   logic [N_REQ-1:0] others;
   logic             dwell_full;
   logic             release_now;
   logic [19:0]      winner_word;
   logic [19:0]      owner_word;

   assign bus.grant     = grant;
   assign bus.owner     = owner;
   assign bus.disp_data = disp_data;
   assign bus.disp_oe   = disp_oe;
   assign bus.scan_tick = scan_tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler <= '0;
         scan_tick <= 1'b0;
      end else begin
         scan_tick <= (prescaler == PW'(TICK_DIV - 1));
         prescaler <= (prescaler == PW'(TICK_DIV - 1)) ? '0 : prescaler + 1'b1;
      end
   end

   // Walk downward so the nearest asserted index after the owner is written last.
   always_comb begin
      winner = owner;
      for (int i = N_REQ; i >= 1; i--) begin
         int idx;
         idx = (int'(owner) + i) % N_REQ;
         if (bus.req[idx]) winner = OW'(idx);
      end
      others      = bus.req & ~(N_REQ'(1) << owner);
      dwell_full  = (dwell == DW'(DWELL_TICKS));
      release_now = !bus.req[owner] || (dwell_full && (|others));
      winner_word = bus.req_data[20*int'(winner) +: 20];
      owner_word  = bus.req_data[20*int'(owner) +: 20];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OW'(N_REQ - 1);
         grant     <= '0;
         disp_data <= '0;
         disp_oe   <= 1'b0;
         dwell     <= '0;
      end else begin
         case (state)
            IDLE, BLANK: begin
               if (|bus.req) begin
                  state     <= GRANT;
                  owner     <= winner;
                  grant     <= N_REQ'(1) << winner;
                  disp_data <= winner_word;
                  disp_oe   <= 1'b1;
                  dwell     <= '0;
               end else begin
                  state     <= IDLE;
                  grant     <= '0;
                  disp_data <= '0;
                  disp_oe   <= 1'b0;
               end
            end
            GRANT: begin
               if (release_now) begin
                  state     <= BLANK;
                  grant     <= '0;
                  disp_data <= '0;
                  disp_oe   <= 1'b0;
               end else begin
                  disp_data <= owner_word;
                  if (scan_tick && !dwell_full) dwell <= dwell + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               grant     <= '0;
               disp_data <= '0;
               disp_oe   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios with literal expectations,
// then random requests checked every cycle against a rule-level model.
module tb_seg_display_arbiter;
   localparam int N  = 4;
   localparam int TD = 4;
   localparam int DT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_display_arbiter_if #(.N_REQ(N)) bus ();

   seg_display_arbiter #(.N_REQ(N), .TICK_DIV(TD), .DWELL_TICKS(DT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // Model state: phase 0 = nobody shown, 1 = owner shown, 2 = blank gap.
   int          mPhase = 0;
   int          mOwner = N - 1;
   int          mHeld  = 0;
   int          mEdges = 0;
   logic [19:0] mData  = '0;
   bit          mTick  = 1'b0;
   bit          modelLive = 1'b0;
   logic [N-1:0] prevGrant = '0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int rrPick(input logic [N-1:0] r, input int from);
      for (int i = 1; i <= N; i++)
         if (r[(from + i) % N]) return (from + i) % N;
      return from;
   endfunction

   function automatic logic [19:0] wordOf(input int k);
      return bus.req_data[20*k +: 20];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mPhase = 0; mOwner = N - 1; mHeld = 0; mEdges = 0; mData = '0; mTick = 1'b0;
         modelLive = 1'b1;
      end else begin
         bit oldTick;
         oldTick = mTick;
         if (mPhase == 1) begin
            logic [N-1:0] waiting;
            waiting = bus.req & ~(N'(1) << mOwner);
            if (!bus.req[mOwner] || (mHeld >= DT && waiting != 0)) begin
               mPhase = 2; mData = '0;
            end else begin
               mData = wordOf(mOwner);
               if (oldTick && mHeld < DT) mHeld++;
            end
         end else if (bus.req != 0) begin
            mOwner = rrPick(bus.req, mOwner);
            mPhase = 1; mHeld = 0; mData = wordOf(mOwner);
         end else begin
            mPhase = 0; mData = '0;
         end
         mEdges++;
         mTick = (mEdges % TD == 0);
      end
   end

   always @(negedge clk) begin
      if (modelLive) begin
         logic [N-1:0] expGrant;
         expGrant = (mPhase == 1) ? N'(1) << mOwner : '0;
         checkOutput("grant", 32'(bus.grant), 32'(expGrant));
         checkOutput("owner", 32'(bus.owner), 32'(mOwner));
         checkOutput("disp_data", 32'(bus.disp_data), 32'(mData));
         checkOutput("disp_oe", 32'(bus.disp_oe), 32'(mPhase == 1));
         checkOutput("scan_tick", 32'(bus.scan_tick), 32'(mTick));
         checkOutput("onehot0", 32'($onehot0(bus.grant)), 32'd1);
         checkOutput("oe_vs_grant", 32'(bus.disp_oe), 32'(|bus.grant));
         checkOutput("no_direct_switch",
                     32'(prevGrant != 0 && bus.grant != 0 && bus.grant != prevGrant), 32'd0);
         prevGrant = bus.grant;
      end
   end

   task automatic applyStimulus(input logic [N-1:0] r);
      bus.req = r;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic waitGrant(input string name, input logic [N-1:0] expected, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.grant == expected) break;
      end
      checkOutput(name, 32'(bus.grant), 32'(expected));
   endtask

   initial begin
      int ticks;
      int bad;
      bus.req      = '0;
      bus.req_data = '0;
      rst          = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_grant", 32'(bus.grant), 32'd0);
      checkOutput("rst_owner", 32'(bus.owner), 32'd3);
      checkOutput("rst_data", 32'(bus.disp_data), 32'd0);
      checkOutput("rst_oe", 32'(bus.disp_oe), 32'd0);
      checkOutput("rst_tick", 32'(bus.scan_tick), 32'd0);

      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         ticks += int'(bus.scan_tick);
      end
      checkOutput("idle_tick_count", 32'(ticks), 32'd5);

      bus.req_data[19:0] = 20'h5A3C1;
      applyStimulus(4'b0001);
      @(negedge clk);
      checkOutput("t2_grant", 32'(bus.grant), 32'b0001);
      checkOutput("t2_data", 32'(bus.disp_data), 32'h5A3C1);
      checkOutput("t2_oe", 32'(bus.disp_oe), 32'd1);
      bus.req_data[19:0] = 20'h00001;
      @(negedge clk);
      checkOutput("t2_data_follow", 32'(bus.disp_data), 32'h00001);
      applyStimulus(4'b0000);
      repeat (3) @(negedge clk);

      doReset();
      applyStimulus(4'b0011);
      waitGrant("t3_first", 4'b0001, 4);
      waitGrant("t3_second", 4'b0010, 40);
      waitGrant("t3_back", 4'b0001, 40);
      applyStimulus(4'b0000);
      repeat (3) @(negedge clk);

      applyStimulus(4'b0100);
      waitGrant("t4_owner2", 4'b0100, 4);
      applyStimulus(4'b1101);
      repeat (4) @(negedge clk);
      checkOutput("t4_held", 32'(bus.grant), 32'b0100);
      applyStimulus(4'b1001);
      @(negedge clk);
      checkOutput("t4_blank_oe", 32'(bus.disp_oe), 32'd0);
      @(negedge clk);
      checkOutput("t4_rr_grant", 32'(bus.grant), 32'b1000);

      applyStimulus(4'b0010);
      waitGrant("t5_owner1", 4'b0010, 4);
      bad = 0;
      for (int i = 0; i < 10 * DT * TD; i++) begin
         @(negedge clk);
         if (bus.grant != 4'b0010) bad++;
      end
      checkOutput("t5_no_blank", 32'(bad), 32'd0);
      applyStimulus(4'b0000);
      @(negedge clk);
      checkOutput("t5_blank_oe", 32'(bus.disp_oe), 32'd0);
      @(negedge clk);
      checkOutput("t5_idle_grant", 32'(bus.grant), 32'd0);

      applyStimulus(4'b1000);
      waitGrant("t6_owner3", 4'b1000, 4);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      applyStimulus(4'b1001);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("t6_grant", 32'(bus.grant), 32'd0);
      checkOutput("t6_oe", 32'(bus.disp_oe), 32'd0);
      checkOutput("t6_data", 32'(bus.disp_data), 32'd0);
      checkOutput("t6_tick", 32'(bus.scan_tick), 32'd0);
      @(negedge clk);
      checkOutput("t6_restart", 32'(bus.grant), 32'b0001);

      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 5) == 0) applyStimulus(N'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) begin
            int k;
            k = $urandom_range(0, N - 1);
            bus.req_data[20*k +: 20] = 20'($urandom);
         end
         rst = ($urandom_range(0, 249) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
